// File: rtl/float_sub_seq_if.sv
// Operand/result handshake bundle for the sequential binary32 subtractor.
// The master side is the producer/consumer; the slave side is the subtractor.
interface float_sub_seq_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid,
        output A,
        output B,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result
    );

    modport slave (
        input  in_valid,
        input  A,
        input  B,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result
    );
endinterface

// File: rtl/float_sub_seq.sv
// Multi-cycle binary32 subtractor (A - B) with truncation and bit-serial normalisation.
// Operands arrive and results leave through valid/ready handshakes on float_sub_seq_if.
module float_sub_seq #(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst,
    float_sub_seq_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ALIGN  = 3'd1,
        ST_ADDSUB = 3'd2,
        ST_NORM   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_s;

    logic [XLEN-1:0] a_r;
    logic [XLEN-1:0] b_r;
    logic [23:0]     mx_r;
    logic [23:0]     my_r;
    logic            sx_r;
    logic            sy_r;
    logic [7:0]      exp_r;
    logic [24:0]     sum_r;
    logic [XLEN-1:0] result_r;
    logic            out_valid_r;
    logic            in_ready_r;

    logic            a_ge_b_s;
    logic [XLEN-1:0] x_s;
    logic [XLEN-1:0] y_s;
    logic [23:0]     x_mant_s;
    logic [23:0]     y_mant_s;
    logic [7:0]      exp_diff_s;
    logic [23:0]     y_shift_s;
    logic [7:0]      exp_inc_s;
    logic [XLEN-1:0] norm_result_s;

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;

    // Alignment: pick the larger magnitude as X and shift Y's mantissa down to X's exponent.
    always_comb begin
        a_ge_b_s = (a_r[30:0] >= b_r[30:0]);
        if (a_ge_b_s) begin
            x_s = a_r;
            y_s = b_r;
        end else begin
            x_s = b_r;
            y_s = a_r;
        end
        // Exponent 0 means zero: no hidden bit, so the operand contributes nothing.
        if (x_s[30:23] == 8'd0) begin
            x_mant_s = 24'd0;
        end else begin
            x_mant_s = {1'b1, x_s[22:0]};
        end
        if (y_s[30:23] == 8'd0) begin
            y_mant_s = 24'd0;
        end else begin
            y_mant_s = {1'b1, y_s[22:0]};
        end
        exp_diff_s = x_s[30:23] - y_s[30:23];
        if (exp_diff_s >= 8'd24) begin
            y_shift_s = 24'd0;
        end else begin
            y_shift_s = y_mant_s >> exp_diff_s;
        end
    end

    // Next-state logic and the value a finishing normalisation step would commit.
    always_comb begin
        state_s       = state_r;
        norm_result_s = {XLEN{1'b0}};
        exp_inc_s     = exp_r + 8'd1;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_s = ST_ALIGN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ALIGN: begin
                state_s = ST_ADDSUB;
            end
            ST_ADDSUB: begin
                state_s = ST_NORM;
            end
            ST_NORM: begin
                if (sum_r == 25'd0) begin
                    norm_result_s = {XLEN{1'b0}};
                    state_s       = ST_DONE;
                end else if (sum_r[24]) begin
                    if (exp_inc_s == 8'd255) begin
                        norm_result_s = {sx_r, 8'hFF, 23'd0};
                    end else begin
                        norm_result_s = {sx_r, exp_inc_s, sum_r[23:1]};
                    end
                    state_s = ST_DONE;
                end else if (sum_r[23]) begin
                    norm_result_s = {sx_r, exp_r, sum_r[22:0]};
                    state_s       = ST_DONE;
                end else if (exp_r == 8'd1) begin
                    norm_result_s = {sx_r, 31'd0};
                    state_s       = ST_DONE;
                end else begin
                    state_s = ST_NORM;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r         <= {XLEN{1'b0}};
            b_r         <= {XLEN{1'b0}};
            mx_r        <= 24'd0;
            my_r        <= 24'd0;
            sx_r        <= 1'b0;
            sy_r        <= 1'b0;
            exp_r       <= 8'd0;
            sum_r       <= 25'd0;
            result_r    <= {XLEN{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Negating B turns the subtraction into an addition.
                    if (bus.in_valid) begin
                        a_r <= bus.A;
                        b_r <= {~bus.B[31], bus.B[30:0]};
                    end else begin
                        a_r <= a_r;
                        b_r <= b_r;
                    end
                end
                ST_ALIGN: begin
                    mx_r  <= x_mant_s;
                    my_r  <= y_shift_s;
                    sx_r  <= x_s[31];
                    sy_r  <= y_s[31];
                    exp_r <= x_s[30:23];
                end
                ST_ADDSUB: begin
                    // X has the larger magnitude, so the difference cannot go negative.
                    if (sx_r == sy_r) begin
                        sum_r <= {1'b0, mx_r} + {1'b0, my_r};
                    end else begin
                        sum_r <= {1'b0, mx_r} - {1'b0, my_r};
                    end
                end
                ST_NORM: begin
                    if (state_s == ST_DONE) begin
                        result_r <= norm_result_s;
                    end else begin
                        sum_r <= sum_r << 1;
                        exp_r <= exp_r - 8'd1;
                    end
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
            out_valid_r <= (state_s == ST_DONE);
            in_ready_r  <= (state_s == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_float_sub_seq.sv
// Self-checking bench for float_sub_seq: directed cases, backpressure, mid-flight reset,
// busy-time input changes and randomized operands against a plain-arithmetic model.
module tb_float_sub_seq;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    float_sub_seq_if #(.XLEN(32)) bus ();

    float_sub_seq #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: A - B as A + (-B), truncating, with the normalisation rules applied arithmetically.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output int lat);
        logic [31:0] bn;
        logic [31:0] x;
        logic [31:0] y;
        logic [47:0] mx;
        logic [47:0] my;
        logic [47:0] s;
        int          d;
        int          e;
        bn  = {~b[31], b[30:0]};
        lat = 4;
        if ((a[30:23] > bn[30:23]) || ((a[30:23] == bn[30:23]) && (a[22:0] >= bn[22:0]))) begin
            x = a;  y = bn;
        end else begin
            x = bn; y = a;
        end
        mx = (x[30:23] == 8'd0) ? 48'd0 : (48'h800000 + 48'(x[22:0]));
        my = (y[30:23] == 8'd0) ? 48'd0 : (48'h800000 + 48'(y[22:0]));
        d  = int'(x[30:23]) - int'(y[30:23]);
        my = (d >= 24) ? 48'd0 : (my >> d);
        s  = (x[31] == y[31]) ? (mx + my) : (mx - my);
        e  = int'(x[30:23]);
        if (s == 48'd0) begin
            r = 32'd0;
        end else if (s >= 48'h1000000) begin
            s = s >> 1;
            e = e + 1;
            r = (e == 255) ? {x[31], 8'hFF, 23'd0} : {x[31], 8'(e), s[22:0]};
        end else begin
            while ((s < 48'h800000) && (e > 1)) begin
                s   = s << 1;
                e   = e - 1;
                lat = lat + 1;
            end
            r = (s < 48'h800000) ? {x[31], 31'd0} : {x[31], 8'(e), s[22:0]};
        end
    endfunction

    // Launch one operation from IDLE and wait (bounded) for out_valid; optionally acknowledge it.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit hold_busy,
                          input bit do_ack, output logic [31:0] res, output int lat, output bit ok);
        bus.A         = a;
        bus.B         = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                if (hold_busy) begin
                    bus.A = ~a;
                    bus.B = a ^ b ^ 32'h1234_5678;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        res          = bus.result;
        bus.in_valid = 1'b0;
        if (do_ack) begin
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
        end
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
        end
        total++;
        if (bus.result !== 32'd0) begin
            bad++; $display("FAIL reset_result got=%h want=00000000", bus.result);
        end
    endtask

    task automatic test_directed();
        logic [31:0] ta [11];
        logic [31:0] tb [11];
        logic [31:0] tr [11];
        int          tl [11];
        logic [31:0] res;
        int          lat;
        bit          ok;
        ta[0]  = 32'h40400000; tb[0]  = 32'h3F800000; tr[0]  = 32'h40000000; tl[0]  = 4;
        ta[1]  = 32'h3F800000; tb[1]  = 32'hBF800000; tr[1]  = 32'h40000000; tl[1]  = 4;
        ta[2]  = 32'h3F800000; tb[2]  = 32'h3FC00000; tr[2]  = 32'hBF000000; tl[2]  = 5;
        ta[3]  = 32'h41200000; tb[3]  = 32'h41200000; tr[3]  = 32'h00000000; tl[3]  = 4;
        ta[4]  = 32'h00000000; tb[4]  = 32'h3F800000; tr[4]  = 32'hBF800000; tl[4]  = 4;
        ta[5]  = 32'h7F7FFFFF; tb[5]  = 32'hFF7FFFFF; tr[5]  = 32'h7F800000; tl[5]  = 4;
        ta[6]  = 32'h80800001; tb[6]  = 32'h80800000; tr[6]  = 32'h80000000; tl[6]  = 4;
        ta[7]  = 32'h00000000; tb[7]  = 32'h00000000; tr[7]  = 32'h00000000; tl[7]  = 4;
        ta[8]  = 32'h3F800000; tb[8]  = 32'h3F800001; tr[8]  = 32'hB4000000; tl[8]  = 27;
        ta[9]  = 32'h4B000000; tb[9]  = 32'h3F800000; tr[9]  = 32'h4AFFFFFE; tl[9]  = 5;
        ta[10] = 32'h4B800000; tb[10] = 32'h3F800000; tr[10] = 32'h4B800000; tl[10] = 4;
        for (int i = 0; i < 11; i++) begin
            run_op(ta[i], tb[i], 1'b0, 1'b1, res, lat, ok);
            total++;
            if (!ok) begin
                bad++; $display("FAIL dir%0d_timeout got=no_out_valid want=out_valid", i);
            end
            total++;
            if (res !== tr[i]) begin
                bad++; $display("FAIL dir%0d_result got=%h want=%h", i, res, tr[i]);
            end
            total++;
            if (lat !== tl[i]) begin
                bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, tl[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res;
        int          lat;
        bit          ok;
        run_op(32'h40400000, 32'h3F800000, 1'b0, 1'b0, res, lat, ok);
        total++;
        if (!ok || res !== 32'h40000000) begin
            bad++; $display("FAIL bp_first got=%h ok=%b want=40000000", res, ok);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (bus.out_valid !== 1'b1 || bus.result !== 32'h40000000 || bus.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d got=v%b r%h rdy%b want=v1 r40000000 rdy0",
                         i, bus.out_valid, bus.result, bus.in_ready);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL bp_release got=rdy%b v%b want=rdy1 v0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int          lat;
        bit          ok;
        bus.A         = 32'h3F800000;
        bus.B         = 32'h3F800001;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 32'd0) begin
            bad++;
            $display("FAIL rst_mid got=rdy%b v%b r%h want=rdy1 v0 r00000000",
                     bus.in_ready, bus.out_valid, bus.result);
        end
        run_op(32'h40000000, 32'h3F000000, 1'b0, 1'b1, res, lat, ok);
        total++;
        if (!ok || res !== 32'h3FC00000) begin
            bad++; $display("FAIL rst_after got=%h ok=%b want=3FC00000", res, ok);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] exp_r;
        int          lat;
        int          exp_lat;
        bit          ok;
        for (int i = 0; i < 20; i++) begin
            a = {$urandom_range(0, 1) == 1, 8'($urandom_range(120, 134)), 23'($urandom)};
            b = {$urandom_range(0, 1) == 1, 8'($urandom_range(120, 134)), 23'($urandom)};
            model(a, b, exp_r, exp_lat);
            run_op(a, b, 1'b1, 1'b1, res, lat, ok);
            total++;
            if (!ok || res !== exp_r || lat !== exp_lat) begin
                bad++;
                $display("FAIL busy%0d a=%h b=%h got=%h/%0d want=%h/%0d", i, a, b, res, lat, exp_r, exp_lat);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] exp_r;
        int          lat;
        int          exp_lat;
        int          ea;
        int          eb;
        bit          ok;
        for (int i = 0; i < 200; i++) begin
            ea = $urandom_range(1, 254);
            eb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 254) : ea + $urandom_range(0, 6) - 3;
            if (eb < 1) eb = 1;
            if (eb > 254) eb = 254;
            if ($urandom_range(0, 9) == 0) ea = 0;
            if ($urandom_range(0, 9) == 0) eb = 0;
            a = {$urandom_range(0, 1) == 1, 8'(ea), 23'($urandom)};
            b = {$urandom_range(0, 1) == 1, 8'(eb), 23'($urandom)};
            if ($urandom_range(0, 7) == 0) b = {a[31], a[30:0] ^ 31'($urandom_range(0, 3))};
            model(a, b, exp_r, exp_lat);
            run_op(a, b, 1'b0, 1'b1, res, lat, ok);
            total++;
            if (!ok || res !== exp_r) begin
                bad++; $display("FAIL rnd%0d_result a=%h b=%h got=%h want=%h", i, a, b, res, exp_r);
            end
            total++;
            if (lat !== exp_lat) begin
                bad++; $display("FAIL rnd%0d_latency a=%h b=%h got=%0d want=%0d", i, a, b, lat, exp_lat);
            end
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.A         = 32'd0;
        bus.B         = 32'd0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
